// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_ALARM
  } state_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;

  // Clamp a nibble that is not a valid BCD digit to 9.
  function automatic bcd_t bcd_sat(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown borrow chain. Purely combinational:
// the owning module holds the digit register and decides when to commit.
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic dec_en,
  input  bcd_t wrap_max,
  input  bcd_t digit_in,
  output bcd_t digit_out,
  output logic borrow_out
);

  // Decrement when enabled; a zero digit wraps to wrap_max and borrows upward.
  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (dec_en) begin
      if (digit_in == 4'd0) begin
        digit_out  = wrap_max;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD MM:SS countdown timer. Loads MM:00 from the minute setter and counts
// down once per TICKS_PER_SEC cycles; at 00:00 pulses done and holds alarm.
// Optional build macro: TIMER_ALARM_TIMEOUT_EN makes ALARM fall back to
// IDLE on its own after ALARM_SECS seconds.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned ALARM_SECS    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  load_val,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  output logic [15:0] time_out,
  output logic        running,
  output logic        done,
  output logic        alarm
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_TERM = PW'(TICKS_PER_SEC - 1);

  if (TICKS_PER_SEC < 2) begin : g_bad_ticks
    $error("TICKS_PER_SEC must be at least 2");
  end
  if (ALARM_SECS < 1) begin : g_bad_alarm
    $error("ALARM_SECS must be at least 1");
  end

  state_t        state_reg;
  logic [15:0]   time_reg;
  logic [PW-1:0] presc_reg;
  logic          running_reg;
  logic          done_reg;
  logic          alarm_reg;

`ifdef TIMER_ALARM_TIMEOUT_EN
  localparam int unsigned ALARM_TICKS = ALARM_SECS * TICKS_PER_SEC;
  localparam int AW = $clog2(ALARM_TICKS);
  localparam logic [AW-1:0] ALARM_TERM = AW'(ALARM_TICKS - 1);
  logic [AW-1:0] alarm_cnt_reg;
`endif

  logic [7:0]  load_time;
  logic [15:0] time_next;
  logic [4:0]  borrow;
  logic        hit_zero;

  assign load_time = {bcd_sat(load_val[7:4]), bcd_sat(load_val[3:0])};

  // Borrow chain: sec units, sec tens (wraps to 5), min units, min tens.
  // borrow[0] is the one-second tick; it only matters while counting.
  assign borrow[0] = (presc_reg == PRESC_TERM);

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_digit
    bcd_digit_down u_digit (
      .dec_en    (borrow[gi]),
      .wrap_max  ((gi == 1) ? SEC_TENS_MAX : BCD_MAX),
      .digit_in  (time_reg[gi*4 +: 4]),
      .digit_out (time_next[gi*4 +: 4]),
      .borrow_out(borrow[gi+1])
    );
  end

  // A borrow out of min tens can only follow 00:00, which never stays in
  // RUN; treating it as zero keeps the counter from wrapping to 99:59.
  assign hit_zero = (time_next == 16'h0000) || borrow[4];

  // Control FSM with registered outputs; command priority clear > start > pause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      time_reg      <= 16'h0000;
      presc_reg     <= '0;
      running_reg   <= 1'b0;
      done_reg      <= 1'b0;
      alarm_reg     <= 1'b0;
`ifdef TIMER_ALARM_TIMEOUT_EN
      alarm_cnt_reg <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      if (clear) begin
        state_reg     <= ST_IDLE;
        time_reg      <= 16'h0000;
        presc_reg     <= '0;
        running_reg   <= 1'b0;
        alarm_reg     <= 1'b0;
`ifdef TIMER_ALARM_TIMEOUT_EN
        alarm_cnt_reg <= '0;
`endif
      end else if (start && (state_reg == ST_IDLE || state_reg == ST_ALARM)) begin
        time_reg      <= {load_time, 8'h00};
        presc_reg     <= '0;
`ifdef TIMER_ALARM_TIMEOUT_EN
        alarm_cnt_reg <= '0;
`endif
        if (load_time == 8'h00) begin
          state_reg   <= ST_ALARM;
          running_reg <= 1'b0;
          alarm_reg   <= 1'b1;
          done_reg    <= 1'b1;
        end else begin
          state_reg   <= ST_RUN;
          running_reg <= 1'b1;
          alarm_reg   <= 1'b0;
        end
      end else if (start && state_reg == ST_PAUSED) begin
        // Resume keeps both the time and the partial second.
        state_reg   <= ST_RUN;
        running_reg <= 1'b1;
      end else begin
        case (state_reg)
          ST_RUN: begin
            // start while running is a no-op and also masks pause.
            if (pause && !start) begin
              state_reg   <= ST_PAUSED;
              running_reg <= 1'b0;
            end else if (presc_reg == PRESC_TERM) begin
              presc_reg <= '0;
              if (hit_zero) begin
                time_reg    <= 16'h0000;
                state_reg   <= ST_ALARM;
                running_reg <= 1'b0;
                alarm_reg   <= 1'b1;
                done_reg    <= 1'b1;
              end else begin
                time_reg <= time_next;
              end
            end else begin
              presc_reg <= presc_reg + PW'(1);
            end
          end
`ifdef TIMER_ALARM_TIMEOUT_EN
          ST_ALARM: begin
            if (alarm_cnt_reg == ALARM_TERM) begin
              state_reg     <= ST_IDLE;
              alarm_reg     <= 1'b0;
              alarm_cnt_reg <= '0;
            end else begin
              alarm_cnt_reg <= alarm_cnt_reg + AW'(1);
            end
          end
`endif
          default: begin
          end
        endcase
      end
    end
  end

  assign time_out = time_reg;
  assign running  = running_reg;
  assign done     = done_reg;
  assign alarm    = alarm_reg;

endmodule
